ux607_mrom_icb_ctrl: RTL and testbench



---
 rtl/ux607_mrom_icb_ctrl.sv | 147 ++++++++++++++
 tb/tb_ux607_mrom_icb_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ux607_mrom_icb_ctrl.sv
// ux607_mrom_icb_ctrl
//   ICB responder in front of the combinational mask ROM. Each accepted
//   command is classified (out of range / write / misaligned / good read).
//   The {rdata, err} result is queued in a small response buffer and returned
//   in order on the ICB response channel.
//
//   Configuration macro: UX607_MROM_RSP_SKID_EN
//     defined   : 2-entry response buffer, registered i_icb_cmd_ready
//     undefined : 1-entry response buffer, i_icb_cmd_ready = ~rsp_valid | rsp_ready
//
//   Ports
//     clk, rst_n        clock, asynchronous active-low reset
//     i_icb_cmd_*       ICB command channel (valid/ready/addr/read/wdata/wmask)
//     i_icb_rsp_*       ICB response channel (valid/ready/rdata/err)
//     rom_addr          ROM word address, combinational from i_icb_cmd_addr
//     rom_dout          ROM word, combinational from rom_addr
//     err_cnt           saturating count of error responses
module ux607_mrom_icb_ctrl #(
    parameter int unsigned   AW     = 32,
    parameter int unsigned   DW     = 32,
    parameter int unsigned   ROM_AW = 12,
    parameter logic [AW-1:0] BASE   = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_icb_cmd_valid,
    output logic              i_icb_cmd_ready,
    input  logic [AW-1:0]     i_icb_cmd_addr,
    input  logic              i_icb_cmd_read,
    input  logic [DW-1:0]     i_icb_cmd_wdata,
    input  logic [DW/8-1:0]   i_icb_cmd_wmask,
    output logic              i_icb_rsp_valid,
    input  logic              i_icb_rsp_ready,
    output logic [DW-1:0]     i_icb_rsp_rdata,
    output logic              i_icb_rsp_err,
    output logic [ROM_AW-3:0] rom_addr,
    input  logic [DW-1:0]     rom_dout,
    output logic [7:0]        err_cnt
);

    logic          cmd_hsk;
    logic          cmd_err;
    logic [DW-1:0] cmd_rdata;

    // ROM is read-only; write payload is deliberately discarded.
    logic unused_ok;
    assign unused_ok = ^{i_icb_cmd_wdata, i_icb_cmd_wmask};

    assign rom_addr = i_icb_cmd_addr[ROM_AW-1:2];

    // All three error classes produce the same {err=1, rdata=0} result, so
    // their priority order collapses into a single OR.
    assign cmd_err   = (i_icb_cmd_addr[AW-1:ROM_AW] != BASE[AW-1:ROM_AW])
                     | ~i_icb_cmd_read
                     | (i_icb_cmd_addr[1:0] != 2'b00);
    assign cmd_rdata = cmd_err ? '0 : rom_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (cmd_hsk && cmd_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

`ifdef UX607_MROM_RSP_SKID_EN
    logic          rsp_hsk;
    logic [DW-1:0] buf_data [2];
    logic          buf_err  [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    count;
    logic [1:0]    count_nxt;
    logic          ready_q;

    assign cmd_hsk = i_icb_cmd_valid & ready_q;
    assign rsp_hsk = i_icb_rsp_valid & i_icb_rsp_ready;

    always_comb begin
        count_nxt = count;
        case ({cmd_hsk, rsp_hsk})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // Ready is computed from next occupancy and registered, so it has no
    // combinational dependence on i_icb_rsp_ready. It comes up one cycle
    // after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                buf_data[i] <= '0;
                buf_err[i]  <= 1'b0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            if (cmd_hsk) begin
                buf_data[wr_ptr] <= cmd_rdata;
                buf_err[wr_ptr]  <= cmd_err;
                wr_ptr           <= ~wr_ptr;
            end
            if (rsp_hsk) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_nxt;
            ready_q <= (count_nxt < 2'd2);
        end
    end

    assign i_icb_cmd_ready = ready_q;
    assign i_icb_rsp_valid = (count != 2'd0);
    assign i_icb_rsp_rdata = buf_data[rd_ptr];
    assign i_icb_rsp_err   = buf_err[rd_ptr];
`else
    logic          valid_q;
    logic          err_q;
    logic [DW-1:0] data_q;

    // rst_n gating keeps ready low while in reset (the buffer is empty then).
    assign i_icb_cmd_ready = rst_n & (~valid_q | i_icb_rsp_ready);
    assign cmd_hsk         = i_icb_cmd_valid & i_icb_cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else if (cmd_hsk) begin
            valid_q <= 1'b1;
            err_q   <= cmd_err;
            data_q  <= cmd_rdata;
        end else if (i_icb_rsp_ready) begin
            valid_q <= 1'b0;
        end
    end

    assign i_icb_rsp_valid = valid_q;
    assign i_icb_rsp_rdata = data_q;
    assign i_icb_rsp_err   = err_q;
`endif

endmodule

// File: tb/tb_ux607_mrom_icb_ctrl.sv
// tb_ux607_mrom_icb_ctrl
//   Self-checking bench for ux607_mrom_icb_ctrl. A behavioural model holds the
//   expected responses in a queue and computes each result directly from the
//   address/read classification rules against a ROM image array.
module tb_ux607_mrom_icb_ctrl;

`ifdef UX607_MROM_RSP_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_icb_cmd_valid;
    logic        i_icb_cmd_ready;
    logic [31:0] i_icb_cmd_addr;
    logic        i_icb_cmd_read;
    logic [31:0] i_icb_cmd_wdata;
    logic [3:0]  i_icb_cmd_wmask;
    logic        i_icb_rsp_valid;
    logic        i_icb_rsp_ready;
    logic [31:0] i_icb_rsp_rdata;
    logic        i_icb_rsp_err;
    logic [9:0]  rom_addr;
    logic [31:0] rom_dout;
    logic [7:0]  err_cnt;

    logic [31:0] rom [1024];
    assign rom_dout = rom[rom_addr];

    always #5 clk = ~clk;

    ux607_mrom_icb_ctrl #(
        .AW     (32),
        .DW     (32),
        .ROM_AW (12),
        .BASE   (BASE)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_icb_cmd_valid (i_icb_cmd_valid),
        .i_icb_cmd_ready (i_icb_cmd_ready),
        .i_icb_cmd_addr  (i_icb_cmd_addr),
        .i_icb_cmd_read  (i_icb_cmd_read),
        .i_icb_cmd_wdata (i_icb_cmd_wdata),
        .i_icb_cmd_wmask (i_icb_cmd_wmask),
        .i_icb_rsp_valid (i_icb_rsp_valid),
        .i_icb_rsp_ready (i_icb_rsp_ready),
        .i_icb_rsp_rdata (i_icb_rsp_rdata),
        .i_icb_rsp_err   (i_icb_rsp_err),
        .rom_addr        (rom_addr),
        .rom_dout        (rom_dout),
        .err_cnt         (err_cnt)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
    } rsp_t;

    rsp_t        q[$];
    int          m_errcnt = 0;
    bit          just_reset = 1'b0;
    bit          rand_rdy = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] bp [3] = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected response from the access rules.
    function automatic rsp_t expect_rsp(input logic [31:0] addr, input logic rd);
        rsp_t r;
        logic [9:0] widx;
        r.data = 32'h0;
        r.err  = 1'b1;
        if ((addr >> 12) != (BASE >> 12)) return r;
        if (!rd) return r;
        if ((addr % 4) != 0) return r;
        widx   = 10'((addr - BASE) >> 2);
        r.err  = 1'b0;
        r.data = rom[widx];
        return r;
    endfunction

    // One clock: check outputs at the falling edge, update the model at the
    // rising edge, then return 1 time unit after it.
    task automatic cycle(output bit acc);
        rsp_t e;
        bit   pop;
        bit   exp_valid;
        @(negedge clk);
        exp_valid = (q.size() != 0);
        check("rsp_valid", 32'(i_icb_rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            check("rsp_rdata", i_icb_rsp_rdata, q[0].data);
            check("rsp_err", 32'(i_icb_rsp_err), 32'(q[0].err));
        end
        check("err_cnt", 32'(err_cnt), 32'(m_errcnt));
        if (!(SKID && just_reset))
            check("cmd_ready", 32'(i_icb_cmd_ready),
                  32'(SKID ? (q.size() < 2) : (q.size() == 0 || i_icb_rsp_ready)));
        acc = i_icb_cmd_valid && i_icb_cmd_ready;
        e.data = 32'h0;
        e.err  = 1'b0;
        if (acc) begin
            check("rom_addr", 32'(rom_addr), 32'(i_icb_cmd_addr[11:2]));
            e = expect_rsp(i_icb_cmd_addr, i_icb_cmd_read);
        end
        pop = exp_valid && i_icb_rsp_ready;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) begin
            q.push_back(e);
            if (e.err && m_errcnt < 255) m_errcnt++;
        end
        just_reset = 1'b0;
        #1;
        if (rand_rdy) i_icb_rsp_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [31:0] addr, input logic rd, input logic [31:0] wd);
        bit acc;
        int n;
        i_icb_cmd_valid = 1'b1;
        i_icb_cmd_addr  = addr;
        i_icb_cmd_read  = rd;
        i_icb_cmd_wdata = wd;
        i_icb_cmd_wmask = 4'($urandom);
        acc = 1'b0;
        n = 0;
        while (!acc && n < 64) begin
            cycle(acc);
            n++;
        end
        if (!acc) check("accept_timeout", 32'(acc), 32'd1);
        i_icb_cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        i_icb_cmd_valid = 1'b0;
        repeat (n) cycle(acc);
    endtask

    task automatic drain();
        bit acc;
        int n;
        i_icb_cmd_valid = 1'b0;
        i_icb_rsp_ready = 1'b1;
        n = 0;
        while (q.size() != 0 && n < 16) begin
            cycle(acc);
            n++;
        end
        if (q.size() != 0) check("drain_timeout", 32'(q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(i_icb_rsp_valid), 32'd0);
        check("rst_rsp_rdata", i_icb_rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(i_icb_rsp_err), 32'd0);
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
        check("rst_cmd_ready", 32'(i_icb_cmd_ready), 32'd0);
        q.delete();
        m_errcnt = 0;
        just_reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int idx;
        int n;
        logic [31:0] a;

        for (int i = 0; i < 1024; i++) rom[i] = $urandom;
        rom[0] = 32'h7FFF_F297;
        rom[1] = 32'h0002_8067;
        rom[2] = 32'h0000_0000;

        i_icb_cmd_valid = 1'b0;
        i_icb_cmd_addr  = 32'h0;
        i_icb_cmd_read  = 1'b1;
        i_icb_cmd_wdata = 32'h0;
        i_icb_cmd_wmask = 4'h0;
        i_icb_rsp_ready = 1'b1;

        #2;
        do_reset();

        // Basic back-to-back reads
        issue(32'h0000_1000, 1'b1, 32'h0);
        check("read0_data", i_icb_rsp_rdata, 32'h7FFF_F297);
        check("read0_err", 32'(i_icb_rsp_err), 32'd0);
        issue(32'h0000_1004, 1'b1, 32'h0);
        check("read1_data", i_icb_rsp_rdata, 32'h0002_8067);
        check("read1_valid", 32'(i_icb_rsp_valid), 32'd1);

        // Write to ROM
        issue(32'h0000_1008, 1'b0, 32'hDEAD_BEEF);
        check("write_err", 32'(i_icb_rsp_err), 32'd1);
        check("write_rdata", i_icb_rsp_rdata, 32'h0);
        check("write_err_cnt", 32'(err_cnt), 32'd1);

        // Misaligned, then out of range
        issue(32'h0000_1002, 1'b1, 32'h0);
        check("misalign_err", 32'(i_icb_rsp_err), 32'd1);
        check("misalign_rdata", i_icb_rsp_rdata, 32'h0);
        issue(32'h0000_2000, 1'b1, 32'h0);
        check("oor_err", 32'(i_icb_rsp_err), 32'd1);
        check("oor_rdata", i_icb_rsp_rdata, 32'h0);
        check("oor_err_cnt", 32'(err_cnt), 32'd3);

        // Word written earlier still reads back its ROM value
        issue(32'h0000_1008, 1'b1, 32'h0);
        check("rom_untouched", i_icb_rsp_rdata, 32'h0);
        check("rom_untouched_err", 32'(i_icb_rsp_err), 32'd0);

        // Range edges
        issue(32'h0000_0FFC, 1'b1, 32'h0);
        issue(32'h0000_1FFC, 1'b1, 32'h0);
        check("top_word_data", i_icb_rsp_rdata, rom[1023]);

        // Error counter saturation
        for (int k = 0; k < 260; k++) issue(BASE + 32'(4 * (k % 1024)), 1'b0, $urandom);
        check("err_cnt_sat", 32'(err_cnt), 32'h0000_00FF);
        drain();

        // Back-pressure
        i_icb_rsp_ready = 1'b0;
        i_icb_cmd_read  = 1'b1;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            i_icb_cmd_valid = 1'b1;
            i_icb_cmd_addr  = bp[idx];
            cycle(acc);
            if (acc) idx++;
        end
        check("bp_accepted", 32'(idx), SKID ? 32'd2 : 32'd1);
        check("bp_ready_low", 32'(i_icb_cmd_ready), 32'd0);
        check("bp_head_hold", i_icb_rsp_rdata, 32'h7FFF_F297);
        i_icb_rsp_ready = 1'b1;
        n = 0;
        while (idx < 3 && n < 32) begin
            i_icb_cmd_valid = 1'b1;
            i_icb_cmd_addr  = bp[idx];
            cycle(acc);
            if (acc) idx++;
            n++;
        end
        check("bp_all_accepted", 32'(idx), 32'd3);
        drain();

        // Randomized traffic with random response back-pressure
        rand_rdy = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            case ($urandom_range(0, 5))
                0: a = BASE + 32'($urandom_range(0, 1023) * 4);
                1: a = BASE + 32'($urandom_range(0, 1023) * 4);
                2: a = BASE + 32'($urandom_range(0, 4095));
                3: a = $urandom;
                4: a = ($urandom_range(0, 1) != 0) ? 32'h0000_0FFC : 32'h0000_2000;
                default: a = 32'hFFFF_FFFF;
            endcase
            if ($urandom_range(0, 4) == 0) idle(1);
            else issue(a, ($urandom_range(0, 3) != 0), $urandom);
        end
        rand_rdy = 1'b0;
        drain();

        // Reset with responses buffered
        i_icb_rsp_ready = 1'b0;
        issue(32'h0000_1004, 1'b1, 32'h0);
        if (SKID) issue(32'h0000_1008, 1'b1, 32'h0);
        check("pre_rst_valid", 32'(i_icb_rsp_valid), 32'd1);
        do_reset();
        i_icb_rsp_ready = 1'b1;
        issue(32'h0000_1000, 1'b1, 32'h0);
        check("post_rst_valid", 32'(i_icb_rsp_valid), 32'd1);
        check("post_rst_data", i_icb_rsp_rdata, 32'h7FFF_F297);
        check("post_rst_err", 32'(i_icb_rsp_err), 32'd0);
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
